// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: three-stage pipelined floating-point multiplier for the
// exception-tagged format {exc[1:0], sign, exponent[WE-1:0], fraction[WF-1:0]}.
// The exception codes are 00 normal, 01 zero, 10 infinity and 11 NaN.
// There are no subnormals. Results that underflow are flushed to zero.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; discards all in-flight work
//   in_valid   operand pair valid
//   in_ready   operands accepted this cycle (combinational, = pipeline enable)
//   x, y       operands, W = WE+WF+3 bits
//   rm         rounding mode: 0 round-to-nearest-even, 1 truncate; travels with operands
//   out_valid  registered result valid
//   out_ready  downstream accepts result
//   r          registered product, held while stalled
module fp_mul_pipe #(
    parameter  int unsigned WE = 8,
    parameter  int unsigned WF = 23,
    localparam int unsigned W  = WE + WF + 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         rm,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] r
);

    localparam int unsigned PW = 2 * WF + 2;   // full mantissa product width
    localparam int unsigned EW = WE + 2;       // two's-complement working exponent

    localparam logic [EW-1:0] BIAS  = {3'b000, {(WE-1){1'b1}}};
    localparam logic [EW-1:0] EMAX  = {2'b00, {WE{1'b1}}};
    localparam logic [EW-1:0] E_ONE = {{(EW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        EXC_NORM = 2'b00,
        EXC_ZERO = 2'b01,
        EXC_INF  = 2'b10,
        EXC_NAN  = 2'b11
    } exc_e;

    // Whole pipeline moves unless a finished result is waiting on downstream.
    logic en;
    assign en        = !out_valid_q || out_ready;
    assign in_ready  = en;

    // ---------------- stage registers ----------------
    logic          s1_valid_q, s1_rm_q, s1_sign_q;
    exc_e          s1_exc_q;
    logic [EW-1:0] s1_exp_q;
    logic [PW-1:0] s1_prod_q;

    logic          s2_valid_q, s2_rm_q, s2_sign_q;
    exc_e          s2_exc_q;
    logic [EW-1:0] s2_exp_q;
    logic [WF-1:0] s2_frac_q;
    logic          s2_guard_q, s2_sticky_q;

    logic          out_valid_q;
    logic [W-1:0]  r_q;

    // ---------------- S1: decode, exponent sum, multiply ----------------
    exc_e          xe, ye;
    logic          s1_sign_d;
    exc_e          s1_exc_d;
    logic [EW-1:0] s1_exp_d;
    logic [PW-1:0] s1_prod_d;

    assign xe = exc_e'(x[W-1:W-2]);
    assign ye = exc_e'(y[W-1:W-2]);

    always_comb begin
        s1_sign_d = x[W-3] ^ y[W-3];
        // Wraps modulo 2^EW; the top bit then reads as the sign.
        s1_exp_d  = {2'b00, x[W-4:WF]} + {2'b00, y[W-4:WF]} - BIAS;
        s1_prod_d = {{(WF+1){1'b0}}, 1'b1, x[WF-1:0]} *
                    {{(WF+1){1'b0}}, 1'b1, y[WF-1:0]};
        if (xe == EXC_NAN || ye == EXC_NAN ||
            (xe == EXC_ZERO && ye == EXC_INF) || (xe == EXC_INF && ye == EXC_ZERO))
            s1_exc_d = EXC_NAN;
        else if (xe == EXC_INF || ye == EXC_INF)
            s1_exc_d = EXC_INF;
        else if (xe == EXC_ZERO || ye == EXC_ZERO)
            s1_exc_d = EXC_ZERO;
        else
            s1_exc_d = EXC_NORM;
    end

    // ---------------- S2: normalise, guard/sticky ----------------
    logic [EW-1:0] s2_exp_d;
    logic [WF-1:0] s2_frac_d;
    logic          s2_guard_d, s2_sticky_d;

    always_comb begin
        if (s1_prod_q[PW-1]) begin
            // Product in [2,4): drop one more bit into guard/sticky.
            s2_exp_d    = s1_exp_q + E_ONE;
            s2_frac_d   = s1_prod_q[PW-2:WF+1];
            s2_guard_d  = s1_prod_q[WF];
            s2_sticky_d = |s1_prod_q[WF-1:0];
        end else begin
            s2_exp_d    = s1_exp_q;
            s2_frac_d   = s1_prod_q[PW-3:WF];
            s2_guard_d  = s1_prod_q[WF-1];
            s2_sticky_d = |s1_prod_q[WF-2:0];
        end
    end

    // ---------------- S3: round, range check, pack ----------------
    logic          inc, carry;
    logic [WF-1:0] frac_r;
    logic [EW-1:0] exp_r;
    logic [W-1:0]  r_d;

    always_comb begin
        inc             = !s2_rm_q && s2_guard_q && (s2_sticky_q || s2_frac_q[0]);
        {carry, frac_r} = {1'b0, s2_frac_q} + {{WF{1'b0}}, inc};
        // A carry out of the fraction leaves frac_r = 0, i.e. mantissa 1.0 one binade up.
        exp_r           = s2_exp_q + {{(EW-1){1'b0}}, carry};
        r_d             = '0;
        unique case (s2_exc_q)
            EXC_NAN:  r_d = {EXC_NAN,  s2_sign_q, {(WE+WF){1'b0}}};
            EXC_INF:  r_d = {EXC_INF,  s2_sign_q, {(WE+WF){1'b0}}};
            EXC_ZERO: r_d = {EXC_ZERO, s2_sign_q, {(WE+WF){1'b0}}};
            default: begin
                if (exp_r[EW-1])
                    r_d = {EXC_ZERO, s2_sign_q, {(WE+WF){1'b0}}};
                else if (exp_r > EMAX)
                    r_d = {EXC_INF, s2_sign_q, {(WE+WF){1'b0}}};
                else
                    r_d = {EXC_NORM, s2_sign_q, exp_r[WE-1:0], frac_r};
            end
        endcase
    end

    // ---------------- state update ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_rm_q     <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_exc_q    <= EXC_NORM;
            s1_exp_q    <= '0;
            s1_prod_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_rm_q     <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_exc_q    <= EXC_NORM;
            s2_exp_q    <= '0;
            s2_frac_q   <= '0;
            s2_guard_q  <= 1'b0;
            s2_sticky_q <= 1'b0;
            out_valid_q <= 1'b0;
            r_q         <= '0;
        end else if (en) begin
            s1_valid_q  <= in_valid;
            s1_rm_q     <= rm;
            s1_sign_q   <= s1_sign_d;
            s1_exc_q    <= s1_exc_d;
            s1_exp_q    <= s1_exp_d;
            s1_prod_q   <= s1_prod_d;
            s2_valid_q  <= s1_valid_q;
            s2_rm_q     <= s1_rm_q;
            s2_sign_q   <= s1_sign_q;
            s2_exc_q    <= s1_exc_q;
            s2_exp_q    <= s2_exp_d;
            s2_frac_q   <= s2_frac_d;
            s2_guard_q  <= s2_guard_d;
            s2_sticky_q <= s2_sticky_d;
            out_valid_q <= s2_valid_q;
            // Bubbles leave r untouched so it always shows the last real product.
            if (s2_valid_q)
                r_q <= r_d;
        end
    end

    assign out_valid = out_valid_q;
    assign r         = r_q;

endmodule

// File: tb/tb_fp_mul_pipe.sv
module tb_fp_mul_pipe;

    localparam int unsigned WE = 8;
    localparam int unsigned WF = 23;
    localparam int unsigned W  = WE + WF + 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] x = '0;
    logic [W-1:0] y = '0;
    logic         rm = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] r;

    fp_mul_pipe #(.WE(WE), .WF(WF)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .rm(rm),
        .out_valid(out_valid), .out_ready(out_ready),
        .r(r)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         m;
        logic [W-1:0] e;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Reference model for the default format, using remainder-vs-half rounding.
    function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic m);
        logic [1:0]  ca, cb;
        logic        s;
        bit [63:0]   ma, mb, p, keep, rem, half;
        int          e;
        ca = a[33:32];
        cb = b[33:32];
        s  = a[31] ^ b[31];
        if (ca == 2'b11 || cb == 2'b11 || (ca == 2'b01 && cb == 2'b10) || (ca == 2'b10 && cb == 2'b01))
            return {2'b11, s, 31'd0};
        if (ca == 2'b10 || cb == 2'b10) return {2'b10, s, 31'd0};
        if (ca == 2'b01 || cb == 2'b01) return {2'b01, s, 31'd0};
        ma = 64'h80_0000 | 64'(a[22:0]);
        mb = 64'h80_0000 | 64'(b[22:0]);
        p  = ma * mb;
        e  = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p >= 64'h8000_0000_0000) begin
            e++;
            keep = p >> 24;
            rem  = p & 64'hFF_FFFF;
            half = 64'h80_0000;
        end else begin
            keep = p >> 23;
            rem  = p & 64'h7F_FFFF;
            half = 64'h40_0000;
        end
        if (!m && (rem > half || (rem == half && keep[0]))) keep++;
        if (keep == 64'h100_0000) begin
            keep = 64'h80_0000;
            e++;
        end
        if (e > 255) return {2'b10, s, 31'd0};
        if (e < 0)   return {2'b01, s, 31'd0};
        return {2'b00, s, 8'(e), keep[22:0]};
    endfunction

    // Present one operand pair, wait (bounded) for acceptance, optionally score it.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                        input logic [W-1:0] expv, input bit push);
        int unsigned tries = 0;
        x = a; y = b; rm = m; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && tries < 200) begin
            @(negedge clk);
            tries++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 for 200 cycles, expected 1");
        end
        @(posedge clk);
        if (push && in_ready) exp_q.push_back(expv);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d results outstanding, expected 0", exp_q.size());
        end
    endtask

    // Scoreboard and hold checker, sampled on the falling edge.
    bit           stalled = 0;
    logic [W-1:0] held_r  = '0;
    always @(negedge clk) begin
        if (rst) begin
            stalled <= 0;
        end else begin
            if (stalled) begin
                check("stall_valid_hold", W'(out_valid), W'(1));
                check("stall_r_hold", r, held_r);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got r=%h, expected no output", r);
                end else begin
                    check("result", r, exp_q.pop_front());
                end
            end
            stalled <= out_valid && !out_ready;
            held_r  <= r;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1);
    end

    bit bp_on;

    initial begin
        tbl[0]  = '{34'h03fc00000, 34'h03fc00000, 1'b0, 34'h040100000};
        tbl[1]  = '{34'h0c0000000, 34'h0c0200000, 1'b0, 34'h040a00000};
        tbl[2]  = '{34'h03f800001, 34'h03fc00000, 1'b0, 34'h03fc00002};
        tbl[3]  = '{34'h03f800001, 34'h03fc00000, 1'b1, 34'h03fc00001};
        tbl[4]  = '{34'h100000000, 34'h200000000, 1'b0, 34'h300000000};
        tbl[5]  = '{34'h0bf800000, 34'h200000000, 1'b0, 34'h280000000};
        tbl[6]  = '{34'h07f800000, 34'h040000000, 1'b0, 34'h200000000};
        tbl[7]  = '{34'h000800000, 34'h000800000, 1'b0, 34'h100000000};
        tbl[8]  = '{34'h07f000000, 34'h040000000, 1'b0, 34'h07f800000};
        tbl[9]  = '{34'h300000000, 34'h0bf800000, 1'b0, 34'h380000000};
        tbl[10] = '{34'h100000000, 34'h0bf800000, 1'b0, 34'h180000000};
        tbl[11] = '{34'h03f800001, 34'h03ffffffe, 1'b0, 34'h040000000};
        tbl[12] = '{34'h03f800001, 34'h03ffffffe, 1'b1, 34'h03fffffff};
        tbl[13] = '{34'h280000000, 34'h0c0000000, 1'b0, 34'h200000000};

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", W'(out_valid), W'(0));
        check("reset_r", r, '0);
        check("reset_in_ready", W'(in_ready), W'(1));

        // Latency of a lone operation
        @(posedge clk); #1;
        send(tbl[0].a, tbl[0].b, tbl[0].m, tbl[0].e, 1);
        @(negedge clk); check("latency_c1", W'(out_valid), W'(0));
        @(negedge clk); check("latency_c2", W'(out_valid), W'(0));
        @(negedge clk); check("latency_c3", W'(out_valid), W'(1));
        wait_drain();

        // Directed vectors, back to back
        @(posedge clk); #1;
        for (int i = 1; i < 14; i++)
            send(tbl[i].a, tbl[i].b, tbl[i].m, tbl[i].e, 1);
        wait_drain();

        // Random normals with pseudo-random backpressure
        bp_on = 1;
        @(posedge clk); #1;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    logic [W-1:0] a, b;
                    logic         m;
                    a = {2'b00, 1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
                    b = {2'b00, 1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
                    m = 1'($urandom_range(0, 1));
                    send(a, b, m, ref_mul(a, b, m), 1);
                end
                wait_drain();
                bp_on = 0;
            end
            begin
                while (bp_on) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Reset mid-stream discards in-flight operations
        send(tbl[1].a, tbl[1].b, 1'b0, '0, 0);
        send(tbl[2].a, tbl[2].b, 1'b0, '0, 0);
        rst = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_reset_quiet", W'(out_valid), W'(0));
        end
        @(posedge clk); #1;
        send(tbl[8].a, tbl[8].b, tbl[8].m, tbl[8].e, 1);
        wait_drain();
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
